// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises, debounces and classifies three coin-slot sensors into single-cycle coin pulses.
// Optional jam detection (sticky jam flag, forced rejects) is built when COIN_JAM_DETECT_EN is defined.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int VAL_A      = 2,
    parameter int VAL_B      = 3,
    parameter int VAL_C      = 5,
    parameter int JAM_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] sense,
    input  logic       accept_en,
    output logic [2:0] coin,
    output logic       reject,
    output logic [7:0] reject_cnt,
    output logic       busy,
    output logic       jam
);
    typedef enum logic [1:0] {IDLE, QUALIFY, DECIDE, RELEASE} state_t;

    localparam logic [7:0] deb_last = 8'(DEB_CYCLES - 1);
    localparam logic [2:0] val_a    = 3'(VAL_A);
    localparam logic [2:0] val_b    = 3'(VAL_B);
    localparam logic [2:0] val_c    = 3'(VAL_C);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || VAL_A < 1 || VAL_A > 7 || VAL_B < 1 || VAL_B > 7 ||
        VAL_C < 1 || VAL_C > 7 || JAM_CYCLES <= DEB_CYCLES) begin : g_bad_params
        $error("coin_acceptor: illegal parameter value");
    end

    state_t     state, state_n;
    logic [2:0] s1, s, lat, lat_n, coin_n, lat_val;
    logic [7:0] cnt, cnt_n;
    logic       reject_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 3'b0;
            s  <= 3'b0;
        end else begin
            s1 <= sense;
            s  <= s1;
        end
    end

    assign lat_val = lat[0] ? val_a : lat[1] ? val_b : val_c;
    assign busy    = state != IDLE;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        lat_n    = lat;
        coin_n   = 3'b0;
        reject_n = 1'b0;
        case (state)
            IDLE:
                if (s != 3'b0) begin
                    lat_n   = s;
                    cnt_n   = 8'd1;
                    state_n = QUALIFY;
                end
            QUALIFY:
                if (s != lat) state_n = IDLE;
                else if (cnt == deb_last) state_n = DECIDE;
                else cnt_n = cnt + 8'd1;
            DECIDE: begin
                if ($onehot(lat) && accept_en && !jam) coin_n = lat_val;
                else reject_n = 1'b1;
                cnt_n   = 8'd0;
                state_n = RELEASE;
            end
            RELEASE:
                // any sensor activity restarts the release qualification
                if (s != 3'b0) cnt_n = 8'd0;
                else if (cnt == deb_last) state_n = IDLE;
                else cnt_n = cnt + 8'd1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            lat        <= 3'b0;
            coin       <= 3'b0;
            reject     <= 1'b0;
            reject_cnt <= 8'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            lat    <= lat_n;
            coin   <= coin_n;
            reject <= reject_n;
            if (reject_n && reject_cnt != 8'hff) reject_cnt <= reject_cnt + 8'd1;
        end
    end

`ifdef COIN_JAM_DETECT_EN
    localparam int hw = $clog2(JAM_CYCLES + 1);
    logic [hw-1:0] hold;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
            jam  <= 1'b0;
        end else begin
            if (s == 3'b0) hold <= '0;
            else if (state == RELEASE && hold != hw'(JAM_CYCLES)) hold <= hold + hw'(1);
            if (hold == hw'(JAM_CYCLES)) jam <= 1'b1;
        end
    end
`else
    assign jam = 1'b0;
`endif
endmodule
